linebuffer_pingpong: RTL and testbench

Double-buffered, parametrised scanline buffer between the sprite/tile draw engine and pixel output. The draw engine fills the back bank with LANES pixels per write while the scanout side reads the front bank one pixel per cycle. Read pixels are optionally cleared to a background colour behind the beam. Banks swap at line start once the draw engine has declared the line done.

---
 rtl/linebuffer_pkg.sv | 20 ++
 rtl/linebuffer_bank.sv | 60 ++++++
 rtl/linebuffer_pingpong.sv | 144 ++++++++++++++
 tb/tb_linebuffer_pingpong.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/linebuffer_pkg.sv
// rtl/linebuffer_pkg.sv - shared types, defaults and lane mapping for the ping-pong line buffer
package linebuffer_pkg;

    localparam int LB_LINE_PIXELS = 4096;
    localparam int LB_COLOUR_W    = 9;
    localparam int LB_LANES       = 8;

    typedef logic [LB_COLOUR_W-1:0] colour_t;

    typedef enum logic {
        FILL = 1'b0,
        DONE = 1'b1
    } lb_state_e;

    // Lane 0 is the rightmost pixel of a draw word, matching the draw engine packing.
    function automatic int lane_pixel_addr(input int word, input int lane, input int lanes);
        return word * lanes + (lanes - 1 - lane);
    endfunction

endpackage

// File: rtl/linebuffer_bank.sv
// rtl/linebuffer_bank.sv - one scanline bank: LANES sub-arrays, pixel read port, masked word write port
module linebuffer_bank
    import linebuffer_pkg::*;
#(
    parameter int LINE_PIXELS = LB_LINE_PIXELS,
    parameter int COLOUR_W    = LB_COLOUR_W,
    parameter int LANES       = LB_LANES
) (
    input  logic                                          clk_i,
    input  logic                                          rst_n_i,
    input  logic                                          rd_en_i,
    input  logic [$clog2(LINE_PIXELS)-1:0]                rd_addr_i,
    output logic [COLOUR_W-1:0]                           rd_data_o,
    input  logic [LANES-1:0]                              wr_mask_i,
    input  logic [$clog2(LINE_PIXELS/LANES)-1:0]          wr_word_i,
    input  logic [LANES*COLOUR_W-1:0]                     wr_data_i
);

    localparam int AW    = $clog2(LINE_PIXELS);
    localparam int LB    = $clog2(LANES);
    localparam int DEPTH = LINE_PIXELS / LANES;

    logic [LANES-1:0][COLOUR_W-1:0] rd_all;
    logic [LB-1:0]                  rd_sel_q;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        // Sub-array index is the low pixel-address bits this lane lands on.
        localparam int K = lane_pixel_addr(0, l, LANES);

        logic [COLOUR_W-1:0] mem [DEPTH];
        logic [COLOUR_W-1:0] rd_q;

        always_ff @(posedge clk_i) begin
            if (wr_mask_i[l]) begin
                mem[wr_word_i] <= wr_data_i[l*COLOUR_W +: COLOUR_W];
            end
        end

        always_ff @(posedge clk_i) begin
            if (!rst_n_i) begin
                rd_q <= '0;
            end else if (rd_en_i) begin
                rd_q <= mem[rd_addr_i[AW-1:LB]];
            end
        end

        assign rd_all[K] = rd_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rd_sel_q <= '0;
        end else if (rd_en_i) begin
            rd_sel_q <= rd_addr_i[LB-1:0];
        end
    end

    assign rd_data_o = rd_all[rd_sel_q];

endmodule

// File: rtl/linebuffer_pingpong.sv
// rtl/linebuffer_pingpong.sv - double-buffered scanline buffer with clear-behind and line-start bank swap
module linebuffer_pingpong
    import linebuffer_pkg::*;
#(
    parameter int                LINE_PIXELS  = LB_LINE_PIXELS,
    parameter int                COLOUR_W     = LB_COLOUR_W,
    parameter int                LANES        = LB_LANES,
    parameter bit                CLEAR_EN     = 1'b1,
    parameter logic [COLOUR_W-1:0] CLEAR_COLOUR = '0
) (
    input  logic                                 clk_pix,
    input  logic                                 rst_pix_n,
    input  logic                                 line_start,
    input  logic                                 scan_en,
    input  logic [$clog2(LINE_PIXELS)-1:0]       scan_addr,
    output logic [COLOUR_W-1:0]                  scan_colour,
    output logic                                 scan_valid,
    input  logic [$clog2(LINE_PIXELS/LANES)-1:0] draw_addr,
    input  logic [LANES-1:0]                     draw_we,
    input  logic [LANES*COLOUR_W-1:0]            draw_colour,
    input  logic                                 draw_done,
    output logic                                 draw_ready,
    output logic                                 front_bank,
    output logic                                 underrun
);

    localparam int AW = $clog2(LINE_PIXELS);
    localparam int LB = $clog2(LANES);
    localparam int WW = AW - LB;

    lb_state_e         state_q, state_d;
    logic              front_q, front_d;
    logic              underrun_q, underrun_d;
    logic              scan_valid_q;
    logic              rd_bank_q;
    logic              clr_pend_q;
    logic              clr_bank_q;
    logic [AW-1:0]     clr_addr_q;

    logic [1:0][COLOUR_W-1:0] bank_rd;
    logic [LANES-1:0]         clr_mask;
    logic                     draw_acc;

    always_comb begin
        state_d    = state_q;
        front_d    = front_q;
        underrun_d = 1'b0;
        case (state_q)
            FILL: begin
                if (line_start) begin
                    // A done arriving with the line start still counts as a completed line.
                    if (draw_done) begin
                        front_d = ~front_q;
                    end else begin
                        underrun_d = 1'b1;
                    end
                end else if (draw_done) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (line_start) begin
                    front_d = ~front_q;
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk_pix) begin
        if (!rst_pix_n) begin
            state_q      <= FILL;
            front_q      <= 1'b0;
            underrun_q   <= 1'b0;
            scan_valid_q <= 1'b0;
            rd_bank_q    <= 1'b0;
            clr_pend_q   <= 1'b0;
            clr_bank_q   <= 1'b0;
            clr_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            front_q      <= front_d;
            underrun_q   <= underrun_d;
            scan_valid_q <= scan_en;
            clr_pend_q   <= CLEAR_EN && scan_en;
            clr_bank_q   <= front_q;
            clr_addr_q   <= scan_addr;
            if (scan_en) begin
                rd_bank_q <= front_q;
            end
        end
    end

    assign draw_ready  = (state_q == FILL);
    assign draw_acc    = rst_pix_n && draw_ready;
    assign clr_mask    = LANES'(1) << (~clr_addr_q[LB-1:0]);

    for (genvar b = 0; b < 2; b++) begin : g_bank
        logic                      clr_hit;
        logic                      draw_hit;
        logic [LANES-1:0]          wr_mask;
        logic [WW-1:0]             wr_word;
        logic [LANES*COLOUR_W-1:0] wr_data;

        assign clr_hit  = rst_pix_n && clr_pend_q && (clr_bank_q == 1'(b));
        assign draw_hit = draw_acc && (front_q != 1'(b));

        // Clear wins the port; the draw side only targets this bank once it is the back bank.
        always_comb begin
            wr_mask = '0;
            wr_word = draw_addr;
            wr_data = draw_colour;
            if (clr_hit) begin
                wr_mask = clr_mask;
                wr_word = clr_addr_q[AW-1:LB];
                wr_data = {LANES{CLEAR_COLOUR}};
            end else if (draw_hit) begin
                wr_mask = draw_we;
            end
        end

        linebuffer_bank #(
            .LINE_PIXELS (LINE_PIXELS),
            .COLOUR_W    (COLOUR_W),
            .LANES       (LANES)
        ) u_bank (
            .clk_i     (clk_pix),
            .rst_n_i   (rst_pix_n),
            .rd_en_i   (scan_en && (front_q == 1'(b))),
            .rd_addr_i (scan_addr),
            .rd_data_o (bank_rd[b]),
            .wr_mask_i (wr_mask),
            .wr_word_i (wr_word),
            .wr_data_i (wr_data)
        );
    end

    assign scan_colour = bank_rd[rd_bank_q];
    assign scan_valid  = scan_valid_q;
    assign front_bank  = front_q;
    assign underrun    = underrun_q;

endmodule

// File: tb/tb_linebuffer_pingpong.sv
// tb/tb_linebuffer_pingpong.sv - self-checking bench for linebuffer_pingpong against a pixel-array model
module tb_linebuffer_pingpong;

    localparam int LP = 4096;
    localparam int CW = 9;
    localparam int L  = 8;
    localparam logic [CW-1:0] CLR = 9'h000;

    logic          clk_pix = 1'b0;
    logic          rst_pix_n;
    logic          line_start;
    logic          scan_en;
    logic [11:0]   scan_addr;
    logic [CW-1:0] scan_colour;
    logic          scan_valid;
    logic [8:0]    draw_addr;
    logic [L-1:0]  draw_we;
    logic [L*CW-1:0] draw_colour;
    logic          draw_done;
    logic          draw_ready;
    logic          front_bank;
    logic          underrun;

    int n_checks = 0;
    int n_errors = 0;

    logic [CW-1:0] m_mem   [2][LP];
    bit            m_known [2][LP];
    bit            m_front, m_done, m_pend, m_pend_bank;
    int            m_pend_addr;
    bit            e_valid, e_ready, e_under, e_front, e_known;
    logic [CW-1:0] e_colour;

    linebuffer_pingpong #(
        .LINE_PIXELS (LP),
        .COLOUR_W    (CW),
        .LANES       (L),
        .CLEAR_EN    (1'b1),
        .CLEAR_COLOUR(CLR)
    ) dut (
        .clk_pix     (clk_pix),
        .rst_pix_n   (rst_pix_n),
        .line_start  (line_start),
        .scan_en     (scan_en),
        .scan_addr   (scan_addr),
        .scan_colour (scan_colour),
        .scan_valid  (scan_valid),
        .draw_addr   (draw_addr),
        .draw_we     (draw_we),
        .draw_colour (draw_colour),
        .draw_done   (draw_done),
        .draw_ready  (draw_ready),
        .front_bank  (front_bank),
        .underrun    (underrun)
    );

    always #5 clk_pix = ~clk_pix;

    task automatic idle();
        line_start  = 1'b0;
        scan_en     = 1'b0;
        scan_addr   = '0;
        draw_addr   = '0;
        draw_we     = '0;
        draw_colour = '0;
        draw_done   = 1'b0;
    endtask

    // Advance one clock and move the model through the same cycle using the driven inputs.
    task automatic tick();
        bit fr;
        int p;
        @(posedge clk_pix);
        if (!rst_pix_n) begin
            m_front  = 1'b0;
            m_done   = 1'b0;
            m_pend   = 1'b0;
            e_valid  = 1'b0;
            e_colour = '0;
            e_known  = 1'b1;
            e_under  = 1'b0;
        end else begin
            fr      = m_front;
            e_valid = scan_en;
            if (scan_en) begin
                e_known  = m_known[fr][scan_addr];
                e_colour = m_mem[fr][scan_addr];
            end
            if (m_pend) begin
                m_mem[m_pend_bank][m_pend_addr]   = CLR;
                m_known[m_pend_bank][m_pend_addr] = 1'b1;
            end
            if (!m_done) begin
                for (int i = 0; i < L; i++) begin
                    if (draw_we[i]) begin
                        p = int'(draw_addr) * L + (L - 1 - i);
                        m_mem[!fr][p]   = draw_colour[i*CW +: CW];
                        m_known[!fr][p] = 1'b1;
                    end
                end
            end
            m_pend      = scan_en;
            m_pend_bank = fr;
            m_pend_addr = int'(scan_addr);
            e_under     = 1'b0;
            if (line_start) begin
                if (m_done || draw_done) begin
                    m_front = !fr;
                    m_done  = 1'b0;
                end else begin
                    e_under = 1'b1;
                end
            end else if (draw_done) begin
                m_done = 1'b1;
            end
        end
        e_front = m_front;
        e_ready = !m_done;
        #1;
    endtask

    task automatic fill_back();
        for (int w = 0; w < LP / L; w++) begin
            idle();
            draw_addr = 9'(w);
            draw_we   = '1;
            for (int i = 0; i < L; i++) draw_colour[i*CW +: CW] = CW'($urandom);
            tick();
        end
        idle();
    endtask

    task automatic test_reset();
        idle();
        rst_pix_n = 1'b0;
        tick();
        tick();
        rst_pix_n = 1'b1;
        n_checks++; if (front_bank !== 1'b0) begin n_errors++; $display("FAIL reset_front: got %b want 0", front_bank); end
        n_checks++; if (draw_ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready: got %b want 1", draw_ready); end
        n_checks++; if (scan_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b want 0", scan_valid); end
        n_checks++; if (scan_colour !== 9'h000) begin n_errors++; $display("FAIL reset_colour: got %h want 000", scan_colour); end
        n_checks++; if (underrun !== 1'b0) begin n_errors++; $display("FAIL reset_underrun: got %b want 0", underrun); end
    endtask

    task automatic test_fill_swap();
        idle();
        draw_addr = 9'd0;
        draw_we   = 8'hFF;
        for (int i = 0; i < L; i++) draw_colour[i*CW +: CW] = CW'(i + 1);
        tick();
        idle(); draw_done = 1'b1; tick();
        n_checks++; if (draw_ready !== 1'b0) begin n_errors++; $display("FAIL fill_ready_drop: got %b want 0", draw_ready); end
        idle(); line_start = 1'b1; tick();
        n_checks++; if (front_bank !== 1'b1) begin n_errors++; $display("FAIL fill_front: got %b want 1", front_bank); end
        n_checks++; if (draw_ready !== 1'b1) begin n_errors++; $display("FAIL fill_ready_rise: got %b want 1", draw_ready); end
        n_checks++; if (underrun !== 1'b0) begin n_errors++; $display("FAIL fill_underrun: got %b want 0", underrun); end
        for (int p = 0; p < L; p++) begin
            idle(); scan_en = 1'b1; scan_addr = 12'(p); tick();
            n_checks++;
            if (scan_valid !== 1'b1 || scan_colour !== CW'(8 - p)) begin
                n_errors++;
                $display("FAIL fill_pixel%0d: got %h valid %b want %h", p, scan_colour, scan_valid, CW'(8 - p));
            end
        end
        idle(); tick();
        n_checks++; if (scan_valid !== 1'b0 || scan_colour !== 9'h001) begin n_errors++; $display("FAIL fill_hold: got %h valid %b want 001 valid 0", scan_colour, scan_valid); end
    endtask

    task automatic test_partial();
        fill_back();
        draw_addr = 9'd3; draw_we = 8'h01; draw_colour = '0; draw_colour[CW-1:0] = 9'h1AB;
        tick();
        idle(); draw_done = 1'b1; tick();
        idle(); line_start = 1'b1; tick();
        n_checks++; if (front_bank !== 1'b0) begin n_errors++; $display("FAIL partial_front: got %b want 0", front_bank); end
        for (int p = 24; p < 32; p++) begin
            idle(); scan_en = 1'b1; scan_addr = 12'(p); tick();
            n_checks++;
            if (scan_colour !== e_colour || (p == 31 && scan_colour !== 9'h1AB)) begin
                n_errors++;
                $display("FAIL partial_pixel%0d: got %h want %h", p, scan_colour, e_colour);
            end
        end
    endtask

    task automatic test_clear_behind();
        for (int p = 0; p < LP; p++) begin
            idle(); scan_en = 1'b1; scan_addr = 12'(p); tick();
            n_checks++;
            if (e_known && scan_colour !== e_colour) begin
                n_errors++;
                $display("FAIL clear_prescan%0d: got %h want %h", p, scan_colour, e_colour);
            end
        end
        for (int s = 0; s < 2; s++) begin
            idle(); draw_done = 1'b1; tick();
            idle(); line_start = 1'b1; tick();
        end
        idle();
        n_checks++; if (front_bank !== 1'b0) begin n_errors++; $display("FAIL clear_front: got %b want 0", front_bank); end
        for (int p = 0; p < LP; p++) begin
            idle(); scan_en = 1'b1; scan_addr = 12'(p); tick();
            n_checks++;
            if (scan_colour !== CLR) begin
                n_errors++;
                $display("FAIL clear_pixel%0d: got %h want %h", p, scan_colour, CLR);
            end
        end
    endtask

    task automatic test_underrun();
        bit f0;
        f0 = e_front;
        idle(); line_start = 1'b1; tick();
        n_checks++; if (underrun !== 1'b1) begin n_errors++; $display("FAIL underrun_pulse: got %b want 1", underrun); end
        n_checks++; if (front_bank !== f0) begin n_errors++; $display("FAIL underrun_front: got %b want %b", front_bank, f0); end
        n_checks++; if (draw_ready !== 1'b1) begin n_errors++; $display("FAIL underrun_ready: got %b want 1", draw_ready); end
        idle(); tick();
        n_checks++; if (underrun !== 1'b0) begin n_errors++; $display("FAIL underrun_width: got %b want 0", underrun); end
        for (int p = 100; p < 116; p++) begin
            idle(); scan_en = 1'b1; scan_addr = 12'(p); tick();
            n_checks++;
            if (scan_colour !== CLR) begin n_errors++; $display("FAIL underrun_rescan%0d: got %h want %h", p, scan_colour, CLR); end
        end
    endtask

    task automatic test_simultaneous();
        fill_back();
        draw_done = 1'b1; line_start = 1'b1; draw_addr = 9'd5; draw_we = 8'hFF;
        for (int i = 0; i < L; i++) draw_colour[i*CW +: CW] = CW'($urandom);
        tick();
        n_checks++; if (front_bank !== 1'b1) begin n_errors++; $display("FAIL simul_front: got %b want 1", front_bank); end
        n_checks++; if (underrun !== 1'b0) begin n_errors++; $display("FAIL simul_underrun: got %b want 0", underrun); end
        n_checks++; if (draw_ready !== 1'b1) begin n_errors++; $display("FAIL simul_ready: got %b want 1", draw_ready); end
        for (int p = 40; p < 48; p++) begin
            idle(); scan_en = 1'b1; scan_addr = 12'(p); tick();
            n_checks++;
            if (scan_colour !== e_colour) begin n_errors++; $display("FAIL simul_swapwrite%0d: got %h want %h", p, scan_colour, e_colour); end
        end
        fill_back();
        draw_done = 1'b1; tick();
        idle(); draw_addr = 9'd7; draw_we = 8'hFF;
        for (int i = 0; i < L; i++) draw_colour[i*CW +: CW] = ~m_mem[0][56 + L - 1 - i];
        tick();
        idle(); line_start = 1'b1; tick();
        n_checks++; if (front_bank !== 1'b0) begin n_errors++; $display("FAIL simul_front2: got %b want 0", front_bank); end
        for (int p = 56; p < 64; p++) begin
            idle(); scan_en = 1'b1; scan_addr = 12'(p); tick();
            n_checks++;
            if (scan_colour !== e_colour) begin n_errors++; $display("FAIL simul_dropped%0d: got %h want %h", p, scan_colour, e_colour); end
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 3000; c++) begin
            idle();
            line_start = ($urandom_range(0, 63) == 0);
            draw_done  = ($urandom_range(0, 31) == 0);
            scan_en    = !line_start && ($urandom_range(0, 1) == 1);
            scan_addr  = 12'($urandom);
            draw_addr  = 9'($urandom);
            draw_we    = 8'($urandom);
            for (int i = 0; i < L; i++) draw_colour[i*CW +: CW] = CW'($urandom);
            tick();
            n_checks++;
            if (scan_valid !== e_valid || front_bank !== e_front || draw_ready !== e_ready ||
                underrun !== e_under || (e_known && scan_colour !== e_colour)) begin
                n_errors++;
                $display("FAIL random_c%0d: got v%b f%b r%b u%b c%h want v%b f%b r%b u%b c%h", c,
                         scan_valid, front_bank, draw_ready, underrun, scan_colour,
                         e_valid, e_front, e_ready, e_under, e_colour);
            end
        end
        idle();
    endtask

    task automatic test_reset_mid();
        idle(); draw_done = 1'b1; tick();
        idle(); scan_en = 1'b1; scan_addr = 12'd200; tick();
        rst_pix_n = 1'b0; tick();
        rst_pix_n = 1'b1; idle();
        n_checks++; if (front_bank !== 1'b0) begin n_errors++; $display("FAIL midreset_front: got %b want 0", front_bank); end
        n_checks++; if (draw_ready !== 1'b1) begin n_errors++; $display("FAIL midreset_ready: got %b want 1", draw_ready); end
        n_checks++; if (scan_valid !== 1'b0) begin n_errors++; $display("FAIL midreset_valid: got %b want 0", scan_valid); end
        n_checks++; if (underrun !== 1'b0) begin n_errors++; $display("FAIL midreset_underrun: got %b want 0", underrun); end
        scan_en = 1'b1; scan_addr = 12'd200; tick();
        n_checks++;
        if (e_known && scan_colour !== e_colour) begin n_errors++; $display("FAIL midreset_pixel: got %h want %h", scan_colour, e_colour); end
        idle(); tick();
    endtask

    initial begin
        rst_pix_n = 1'b0;
        idle();
        test_reset();
        test_fill_swap();
        test_partial();
        test_clear_behind();
        test_underrun();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
